// File: rtl/pollard_pkg.sv
// Shared defaults and FSM state encoding for the Pollard p-1 factoriser.
package pollard_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int BOUND_DEF = 1000;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        EXP,
        MUL,
        GCD,
        CHECK,
        DONE
    } state_t;

endpackage

// File: rtl/pollard_modmul.sv
// Shift-add modular multiplier: r = x*y mod m, MSB-first over y, one bit per cycle.
module pollard_modmul
    import pollard_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] m,
    output logic             busy,
    output logic [WIDTH-1:0] r
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] xq, yq, mq;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   m_ext, dbl, dred, sum, sred;

    // acc < m keeps every partial below 2m, so WIDTH+1 bits never overflow
    always_comb begin
        m_ext = {1'b0, mq};
        dbl   = {r, 1'b0};
        dred  = (dbl >= m_ext) ? dbl - m_ext : dbl;
        sum   = dred + {1'b0, (yq[WIDTH-1] ? xq : '0)};
        sred  = (sum >= m_ext) ? sum - m_ext : sum;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            xq   <= '0;
            yq   <= '0;
            mq   <= '0;
            r    <= '0;
            cnt  <= '0;
            busy <= 1'b0;
        end else if (start) begin
            xq   <= x;
            yq   <= y;
            mq   <= m;
            r    <= '0;
            cnt  <= CW'(WIDTH - 1);
            busy <= 1'b1;
        end else if (busy) begin
            r  <= WIDTH'(sred);
            yq <= yq << 1;
            if (cnt == '0) busy <= 1'b0;
            else           cnt  <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/pollard_pm1_main.sv
// Pollard p-1 factoriser: a_k = 2^(k!) mod n, then gcd(a_k-1, n) per k.
module pollard_pm1_main
    import pollard_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int BOUND = BOUND_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] prime1,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] n_q, a, r, k, gx, gy, g, mul_x, mul_y, mul_r;
    logic [CW-1:0]    bits_rem, bit_idx;
    logic [CW:0]      shift;
    logic             mul_phase, mul_start, mul_busy;

    function automatic logic [CW-1:0] top_bit(input logic [WIDTH-1:0] v);
        top_bit = '0;
        for (int unsigned i = 0; i < WIDTH; i++)
            if (v[i]) top_bit = CW'(i);
    endfunction

    always_comb bit_idx = bits_rem - CW'(1);

    pollard_modmul #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mul_start),
        .x     (mul_x),
        .y     (mul_y),
        .m     (n_q),
        .busy  (mul_busy),
        .r     (mul_r)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            n_q       <= '0;
            a         <= '0;
            r         <= '0;
            k         <= '0;
            gx        <= '0;
            gy        <= '0;
            g         <= '0;
            mul_x     <= '0;
            mul_y     <= '0;
            bits_rem  <= '0;
            shift     <= '0;
            mul_phase <= 1'b0;
            mul_start <= 1'b0;
            prime1    <= '0;
            done      <= 1'b0;
        end else if (state == IDLE || n != n_q) begin
            n_q       <= n;
            prime1    <= '0;
            done      <= 1'b0;
            mul_start <= 1'b0;
            state     <= INIT;
        end else begin
            mul_start <= 1'b0;
            case (state)
                INIT: begin
                    if (n_q < WIDTH'(4)) begin
                        prime1 <= n_q;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else if (!n_q[0]) begin
                        prime1 <= WIDTH'(2);
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        a         <= WIDTH'(2);
                        r         <= WIDTH'(2);
                        k         <= WIDTH'(2);
                        bits_rem  <= top_bit(WIDTH'(2));
                        mul_phase <= 1'b0;
                        state     <= EXP;
                    end
                end
                // r starts at a, covering the leading 1 of k; remaining bits follow
                EXP: begin
                    if (bits_rem == '0) begin
                        a     <= r;
                        gx    <= (r == '0) ? n_q - WIDTH'(1) : r - WIDTH'(1);
                        gy    <= n_q;
                        shift <= '0;
                        state <= GCD;
                    end else begin
                        mul_x     <= r;
                        mul_y     <= mul_phase ? a : r;
                        mul_start <= 1'b1;
                        state     <= MUL;
                    end
                end
                MUL: begin
                    if (!mul_start && !mul_busy) begin
                        r <= mul_r;
                        if (!mul_phase && k[bit_idx]) begin
                            mul_phase <= 1'b1;
                        end else begin
                            mul_phase <= 1'b0;
                            bits_rem  <= bits_rem - CW'(1);
                        end
                        state <= EXP;
                    end
                end
                GCD: begin
                    if (gx == '0) begin
                        g     <= gy << shift;
                        state <= CHECK;
                    end else if (!gx[0] && !gy[0]) begin
                        gx    <= gx >> 1;
                        gy    <= gy >> 1;
                        shift <= shift + (CW+1)'(1);
                    end else if (!gx[0]) begin
                        gx <= gx >> 1;
                    end else if (!gy[0]) begin
                        gy <= gy >> 1;
                    end else if (gx >= gy) begin
                        gx <= gx - gy;
                    end else begin
                        gy <= gy - gx;
                    end
                end
                CHECK: begin
                    if (g > WIDTH'(1) && g < n_q) begin
                        prime1 <= g;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else if (g == n_q || k == WIDTH'(BOUND)) begin
                        prime1 <= n_q;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        k         <= k + WIDTH'(1);
                        r         <= a;
                        bits_rem  <= top_bit(k + WIDTH'(1));
                        mul_phase <= 1'b0;
                        state     <= EXP;
                    end
                end
                DONE:    state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pollard_pm1_main.sv
// Directed bench for pollard_pm1_main with a queue of expected factors.
module tb_pollard_pm1_main;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] n = '0;
    logic [31:0] prime1;
    logic        done;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    pollard_pm1_main #(.WIDTH(32), .BOUND(1000)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .n      (n),
        .prime1 (prime1),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic step(input int c);
        repeat (c) @(posedge clk);
        #1;
    endtask

    task automatic run_case(input string tag, input logic [31:0] nv,
                            input logic [31:0] expv, input int budget);
        int cyc;
        logic [31:0] e;
        n = nv;
        exp_q.push_back(expv);
        cyc = 0;
        while (cyc < budget) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done === 1'b1) break;
        end
        check({tag, "_done"}, {31'b0, done}, 32'd1);
        e = exp_q.pop_front();
        check(tag, prime1, e);
    endtask

    initial begin
        step(3);
        check("reset_prime1", prime1, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        rst_n = 1'b1;

        run_case("n485", 32'd485, 32'd5, 2000);
        step(5);
        check("n485_hold", prime1, 32'd5);

        n = 32'd35;
        step(1);
        check("change_clr_prime1", prime1, 32'd0);
        check("change_clr_done", {31'b0, done}, 32'd0);
        run_case("n35", 32'd35, 32'd7, 5000);

        run_case("n1147", 32'd1147, 32'd31, 5000);
        run_case("n13", 32'd13, 32'd13, 5000);
        run_case("n10", 32'd10, 32'd2, 50);
        run_case("n3", 32'd3, 32'd3, 50);
        run_case("n1", 32'd1, 32'd1, 50);
        run_case("n4", 32'd4, 32'd2, 50);

        n = 32'd485;
        step(20);
        check("busy_prime1", prime1, 32'd0);
        check("busy_done", {31'b0, done}, 32'd0);
        rst_n = 1'b0;
        step(1);
        check("midrst_prime1", prime1, 32'd0);
        check("midrst_done", {31'b0, done}, 32'd0);
        rst_n = 1'b1;
        run_case("n485_after_rst", 32'd485, 32'd5, 2000);

        n = 32'd1147;
        step(20);
        run_case("n35_restart", 32'd35, 32'd7, 5000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
